// File: rtl/pipe_ctrl_unit.sv
// Pipeline control unit: carries decoded controls from ID through ID/EX,
// EX/MEM and MEM/WB, detects load-use hazards and inserts bubbles, produces
// forwarding selects and redirects fetch for branches/jumps resolved in ID.
module pipe_ctrl_unit #(
    parameter int RA_W  = 5,
    parameter int AOP_W = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             RegDst_i,
    input  logic             ALUSrc_i,
    input  logic             MemtoReg_i,
    input  logic             RegWrite_i,
    input  logic             MemWrite_i,
    input  logic             MemRead_i,
    input  logic             Branch_i,
    input  logic             Jump_i,
    input  logic [AOP_W-1:0] ALUOp_i,
    input  logic [RA_W-1:0]  rs_i,
    input  logic [RA_W-1:0]  rt_i,
    input  logic [RA_W-1:0]  rd_i,
    input  logic             eq_i,
    output logic             PCWrite_o,
    output logic             IFIDWrite_o,
    output logic             IFFlush_o,
    output logic [1:0]       PCSrc_o,
    output logic             ALUSrc_ex_o,
    output logic [AOP_W-1:0] ALUOp_ex_o,
    output logic [1:0]       ForwardA_o,
    output logic [1:0]       ForwardB_o,
    output logic             MemRead_mem_o,
    output logic             MemWrite_mem_o,
    output logic             RegWrite_wb_o,
    output logic             MemtoReg_wb_o,
    output logic [RA_W-1:0]  dst_wb_o
);

    // ID/EX stage
    logic             regdst_ex, alusrc_ex, memtoreg_ex, regwrite_ex;
    logic             memwrite_ex, memread_ex;
    logic [AOP_W-1:0] aluop_ex;
    logic [RA_W-1:0]  rs_ex, rt_ex, rd_ex, dst_ex;

    // EX/MEM stage
    logic             memtoreg_mem, regwrite_mem, memwrite_mem, memread_mem;
    logic [RA_W-1:0]  dst_mem;

    // MEM/WB stage
    logic             memtoreg_wb, regwrite_wb;
    logic [RA_W-1:0]  dst_wb;

    logic             stall;
    logic             no_reg_result;

    // Load-use hazard: a load in EX whose target is read by the instruction in ID
    always_comb begin
        stall = memread_ex && (rt_ex != '0) && ((rt_ex == rs_i) || (rt_ex == rt_i));
    end

    // Stores, branches and jumps carry don't-care bits for result/load controls
    always_comb begin
        no_reg_result = MemWrite_i | Branch_i | Jump_i;
    end

    // ID/EX register: gated decoder controls, or a bubble while stalled
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            regdst_ex   <= 1'b0;
            alusrc_ex   <= 1'b0;
            memtoreg_ex <= 1'b0;
            regwrite_ex <= 1'b0;
            memwrite_ex <= 1'b0;
            memread_ex  <= 1'b0;
            aluop_ex    <= '0;
            rs_ex       <= '0;
            rt_ex       <= '0;
            rd_ex       <= '0;
        end else begin
            rs_ex <= rs_i;
            rt_ex <= rt_i;
            rd_ex <= rd_i;
            if (stall) begin
                regdst_ex   <= 1'b0;
                alusrc_ex   <= 1'b0;
                memtoreg_ex <= 1'b0;
                regwrite_ex <= 1'b0;
                memwrite_ex <= 1'b0;
                memread_ex  <= 1'b0;
                aluop_ex    <= '0;
            end else begin
                regdst_ex   <= RegDst_i   & ~no_reg_result;
                alusrc_ex   <= ALUSrc_i;
                memtoreg_ex <= MemtoReg_i & ~no_reg_result;
                regwrite_ex <= RegWrite_i & ~no_reg_result;
                memwrite_ex <= MemWrite_i;
                memread_ex  <= MemRead_i  & ~no_reg_result;
                aluop_ex    <= ALUOp_i;
            end
        end
    end

    // Destination register selected in EX
    always_comb begin
        dst_ex = regdst_ex ? rd_ex : rt_ex;
    end

    // EX/MEM register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            memtoreg_mem <= 1'b0;
            regwrite_mem <= 1'b0;
            memwrite_mem <= 1'b0;
            memread_mem  <= 1'b0;
            dst_mem      <= '0;
        end else begin
            memtoreg_mem <= memtoreg_ex;
            regwrite_mem <= regwrite_ex;
            memwrite_mem <= memwrite_ex;
            memread_mem  <= memread_ex;
            dst_mem      <= dst_ex;
        end
    end

    // MEM/WB register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            memtoreg_wb <= 1'b0;
            regwrite_wb <= 1'b0;
            dst_wb      <= '0;
        end else begin
            memtoreg_wb <= memtoreg_mem;
            regwrite_wb <= regwrite_mem;
            dst_wb      <= dst_mem;
        end
    end

    // Fetch redirect for jumps/taken branches; a stall holds off the redirect
    always_comb begin
        PCSrc_o   = 2'b00;
        IFFlush_o = 1'b0;
        if (!stall) begin
            if (Jump_i) begin
                PCSrc_o   = 2'b10;
                IFFlush_o = 1'b1;
            end else if (Branch_i && eq_i) begin
                PCSrc_o   = 2'b01;
                IFFlush_o = 1'b1;
            end
        end
    end

    // Forwarding selects, EX/MEM result preferred over MEM/WB
    always_comb begin
        ForwardA_o = 2'b00;
        ForwardB_o = 2'b00;
        if (regwrite_mem && (dst_mem != '0) && (dst_mem == rs_ex)) begin
            ForwardA_o = 2'b10;
        end else if (regwrite_wb && (dst_wb != '0) && (dst_wb == rs_ex)) begin
            ForwardA_o = 2'b01;
        end
        if (regwrite_mem && (dst_mem != '0) && (dst_mem == rt_ex)) begin
            ForwardB_o = 2'b10;
        end else if (regwrite_wb && (dst_wb != '0) && (dst_wb == rt_ex)) begin
            ForwardB_o = 2'b01;
        end
    end

    // Stage controls to the datapath
    always_comb begin
        PCWrite_o      = ~stall;
        IFIDWrite_o    = ~stall;
        ALUSrc_ex_o    = alusrc_ex;
        ALUOp_ex_o     = aluop_ex;
        MemRead_mem_o  = memread_mem;
        MemWrite_mem_o = memwrite_mem;
        RegWrite_wb_o  = regwrite_wb;
        MemtoReg_wb_o  = memtoreg_wb;
        dst_wb_o       = dst_wb;
    end

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Self-checking bench for pipe_ctrl_unit: directed vector table, a reset
// mid-stall sequence, and randomized stimulus against an issue-history model.
module tb_pipe_ctrl_unit;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       RegDst_i, ALUSrc_i, MemtoReg_i, RegWrite_i;
    logic       MemWrite_i, MemRead_i, Branch_i, Jump_i;
    logic [1:0] ALUOp_i;
    logic [4:0] rs_i, rt_i, rd_i;
    logic       eq_i;
    logic       PCWrite_o, IFIDWrite_o, IFFlush_o;
    logic [1:0] PCSrc_o;
    logic       ALUSrc_ex_o;
    logic [1:0] ALUOp_ex_o;
    logic [1:0] ForwardA_o, ForwardB_o;
    logic       MemRead_mem_o, MemWrite_mem_o, RegWrite_wb_o, MemtoReg_wb_o;
    logic [4:0] dst_wb_o;

    int checks = 0;
    int errors = 0;

    pipe_ctrl_unit #(.RA_W(5), .AOP_W(2)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .RegDst_i(RegDst_i), .ALUSrc_i(ALUSrc_i), .MemtoReg_i(MemtoReg_i),
        .RegWrite_i(RegWrite_i), .MemWrite_i(MemWrite_i), .MemRead_i(MemRead_i),
        .Branch_i(Branch_i), .Jump_i(Jump_i), .ALUOp_i(ALUOp_i),
        .rs_i(rs_i), .rt_i(rt_i), .rd_i(rd_i), .eq_i(eq_i),
        .PCWrite_o(PCWrite_o), .IFIDWrite_o(IFIDWrite_o), .IFFlush_o(IFFlush_o),
        .PCSrc_o(PCSrc_o), .ALUSrc_ex_o(ALUSrc_ex_o), .ALUOp_ex_o(ALUOp_ex_o),
        .ForwardA_o(ForwardA_o), .ForwardB_o(ForwardB_o),
        .MemRead_mem_o(MemRead_mem_o), .MemWrite_mem_o(MemWrite_mem_o),
        .RegWrite_wb_o(RegWrite_wb_o), .MemtoReg_wb_o(MemtoReg_wb_o),
        .dst_wb_o(dst_wb_o)
    );

    always #5 clk_i = ~clk_i;

    // control vector order: {RegDst, ALUSrc, MemtoReg, RegWrite, MemWrite, MemRead, Branch, Jump}
    localparam logic [7:0] C_NOP  = 8'b0000_0000;
    localparam logic [7:0] C_R    = 8'b1001_0000;
    localparam logic [7:0] C_LW   = 8'b0111_0100;
    localparam logic [7:0] C_ADDI = 8'b0101_0000;
    localparam logic [7:0] C_BEQX = 8'b0011_0010;  // beq with junk RegWrite/MemtoReg
    localparam logic [7:0] C_BEQY = 8'b1000_0010;  // beq with junk RegDst
    localparam logic [7:0] C_BEQ  = 8'b0000_0010;
    localparam logic [7:0] C_JX   = 8'b1011_0101;  // j with junk result/load bits

    typedef struct {
        logic [7:0] ctl;
        logic [1:0] aop;
        logic [4:0] rs, rt, rd;
        logic       eq;
        logic       pcw, flush;
        logic [1:0] pcsrc;
        logic       asrc;
        logic [1:0] aop_ex, fa, fb;
        logic       mr, mw, rw, m2r;
        logic [4:0] dst;
        logic       cf, cd;   // check forwarding / dst_wb this cycle
    } vec_t;

    vec_t vecs[$];

    function automatic void add(
        input logic [7:0] ctl, input logic [1:0] aop,
        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd, input logic eq,
        input logic pcw, input logic flush, input logic [1:0] pcsrc, input logic asrc,
        input logic [1:0] aop_ex, input logic [1:0] fa, input logic [1:0] fb,
        input logic mr, input logic mw, input logic rw, input logic m2r,
        input logic [4:0] dst, input logic cf, input logic cd);
        vec_t v;
        v.ctl = ctl; v.aop = aop; v.rs = rs; v.rt = rt; v.rd = rd; v.eq = eq;
        v.pcw = pcw; v.flush = flush; v.pcsrc = pcsrc; v.asrc = asrc;
        v.aop_ex = aop_ex; v.fa = fa; v.fb = fb; v.mr = mr; v.mw = mw;
        v.rw = rw; v.m2r = m2r; v.dst = dst; v.cf = cf; v.cd = cd;
        vecs.push_back(v);
    endfunction

    task automatic drive(input logic [7:0] ctl, input logic [1:0] aop,
                         input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic eq);
        {RegDst_i, ALUSrc_i, MemtoReg_i, RegWrite_i,
         MemWrite_i, MemRead_i, Branch_i, Jump_i} = ctl;
        ALUOp_i = aop;
        rs_i = rs; rt_i = rt; rd_i = rd; eq_i = eq;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic cmp_all(input string tag, input vec_t e);
        chk({tag, " PCWrite"},   int'(PCWrite_o),      int'(e.pcw));
        chk({tag, " IFIDWrite"}, int'(IFIDWrite_o),    int'(e.pcw));
        chk({tag, " IFFlush"},   int'(IFFlush_o),      int'(e.flush));
        chk({tag, " PCSrc"},     int'(PCSrc_o),        int'(e.pcsrc));
        chk({tag, " ALUSrc_ex"}, int'(ALUSrc_ex_o),    int'(e.asrc));
        chk({tag, " ALUOp_ex"},  int'(ALUOp_ex_o),     int'(e.aop_ex));
        chk({tag, " MemRead"},   int'(MemRead_mem_o),  int'(e.mr));
        chk({tag, " MemWrite"},  int'(MemWrite_mem_o), int'(e.mw));
        chk({tag, " RegWrite"},  int'(RegWrite_wb_o),  int'(e.rw));
        chk({tag, " MemtoReg"},  int'(MemtoReg_wb_o),  int'(e.m2r));
        if (e.cf) begin
            chk({tag, " ForwardA"}, int'(ForwardA_o), int'(e.fa));
            chk({tag, " ForwardB"}, int'(ForwardB_o), int'(e.fb));
        end
        if (e.cd) chk({tag, " dst_wb"}, int'(dst_wb_o), int'(e.dst));
    endtask

    // ---------------- reference model ----------------
    // Instructions issued into EX, newest first: age 0 = EX, 1 = MEM, 2 = WB.
    typedef struct {
        bit       bub, wr, ld, st, m2r, asrc;
        bit [1:0] aop;
        bit [4:0] rs, rt, dst;
    } ent_t;

    ent_t issued[$];

    function automatic void model_reset();
        ent_t z;
        z = '{default: 0};
        issued.delete();
        for (int i = 0; i < 3; i++) issued.push_back(z);
    endfunction

    function automatic bit model_stall();
        ent_t ex = issued[0];
        return ex.ld && ex.rt != 0 && (ex.rt == rs_i || ex.rt == rt_i);
    endfunction

    function automatic bit [1:0] model_fwd(input bit [4:0] r);
        if (issued[1].wr && issued[1].dst != 0 && issued[1].dst == r) return 2'b10;
        if (issued[2].wr && issued[2].dst != 0 && issued[2].dst == r) return 2'b01;
        return 2'b00;
    endfunction

    function automatic vec_t model_expect();
        vec_t e;
        bit   s = model_stall();
        e = '{default: '0};
        e.pcw   = !s;
        e.pcsrc = 2'b00;
        e.flush = 1'b0;
        if (!s && Jump_i)                 begin e.pcsrc = 2'b10; e.flush = 1'b1; end
        else if (!s && Branch_i && eq_i)  begin e.pcsrc = 2'b01; e.flush = 1'b1; end
        e.asrc   = issued[0].asrc;
        e.aop_ex = issued[0].aop;
        e.cf     = !issued[0].bub;
        e.fa     = model_fwd(issued[0].rs);
        e.fb     = model_fwd(issued[0].rt);
        e.mr     = issued[1].ld;
        e.mw     = issued[1].st;
        e.rw     = issued[2].wr;
        e.m2r    = issued[2].m2r;
        e.cd     = !issued[2].bub;
        e.dst    = issued[2].dst;
        return e;
    endfunction

    // Advance the model by one clock edge with the currently driven inputs.
    function automatic void model_clock();
        ent_t n;
        bit   kill = MemWrite_i || Branch_i || Jump_i;
        n = '{default: 0};
        if (model_stall()) begin
            n.bub = 1;
        end else begin
            n.wr   = RegWrite_i && !kill;
            n.ld   = MemRead_i && !kill;
            n.m2r  = MemtoReg_i && !kill;
            n.st   = MemWrite_i;
            n.asrc = ALUSrc_i;
            n.aop  = ALUOp_i;
            n.rs   = rs_i;
            n.rt   = rt_i;
            n.dst  = (RegDst_i && !kill) ? rd_i : rt_i;
        end
        issued.push_front(n);
        void'(issued.pop_back());
    endfunction

    initial begin
        vec_t e;
        drive(C_NOP, 2'b00, 5'd0, 5'd0, 5'd0, 1'b0);
        rst_i = 1'b1;

        // ---- reset state ----
        @(negedge clk_i);
        e = '{default: '0};
        e.pcw = 1; e.cf = 1; e.cd = 1;
        cmp_all("reset", e);
        @(posedge clk_i); #1;
        rst_i = 1'b0;

        // ---- directed vector table (one row per cycle) ----
        //   ctl     aop    rs rt rd eq | pcw fl pcsrc as aopx  fa     fb    mr mw rw m2 dst cf cd
        add(C_ADDI, 2'b01, 0, 1, 0, 0,   1, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 1);
        add(C_NOP,  2'b00, 0, 0, 0, 0,   1, 0, 2'b00, 1, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 1);
        add(C_NOP,  2'b00, 0, 0, 0, 0,   1, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 1);
        add(C_NOP,  2'b00, 0, 0, 0, 0,   1, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 0, 1, 0, 1, 1, 1);
        // lw r2; add r3,r2,r4 -> one stall, bubble, then MEM/WB forward
        add(C_LW,   2'b00, 0, 2, 0, 0,   1, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 1);
        add(C_R,    2'b10, 2, 4, 3, 0,   0, 0, 2'b00, 1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 1);
        add(C_R,    2'b10, 2, 4, 3, 0,   1, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 0, 0, 1);
        add(C_NOP,  2'b00, 0, 0, 0, 0,   1, 0, 2'b00, 0, 2'b10, 2'b01, 2'b00, 0, 0, 1, 1, 2, 1, 1);
        add(C_NOP,  2'b00, 0, 0, 0, 0,   1, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 0);
        // add r5,r1,r1; sub r6,r5,r5 -> EX/MEM forward; with a NOP between -> MEM/WB
        add(C_R,    2'b10, 1, 1, 5, 0,   1, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 0, 1, 0, 3, 1, 1);
        add(C_R,    2'b10, 5, 5, 6, 0,   1, 0, 2'b00, 0, 2'b10, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 1);
        add(C_NOP,  2'b00, 0, 0, 0, 0,   1, 0, 2'b00, 0, 2'b10, 2'b10, 2'b10, 0, 0, 0, 0, 0, 1, 1);
        add(C_R,    2'b10, 1, 1, 5, 0,   1, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 0, 1, 0, 5, 1, 1);
        add(C_NOP,  2'b00, 0, 0, 0, 0,   1, 0, 2'b00, 0, 2'b10, 2'b00, 2'b00, 0, 0, 1, 0, 6, 1, 1);
        add(C_R,    2'b10, 5, 5, 6, 0,   1, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 1);
        add(C_NOP,  2'b00, 0, 0, 0, 0,   1, 0, 2'b00, 0, 2'b10, 2'b01, 2'b01, 0, 0, 1, 0, 5, 1, 1);
        // beq taken, beq not taken, jump; junk decoder bits must not propagate
        add(C_BEQX, 2'b01, 1, 1, 0, 1,   1, 1, 2'b01, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 1);
        add(C_BEQY, 2'b01, 2, 3, 0, 0,   1, 0, 2'b00, 0, 2'b01, 2'b00, 2'b00, 0, 0, 1, 0, 6, 1, 1);
        add(C_JX,   2'b00, 0, 0, 0, 0,   1, 1, 2'b10, 0, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 1);
        add(C_NOP,  2'b00, 0, 0, 0, 0,   1, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 1, 1, 1);
        add(C_NOP,  2'b00, 0, 0, 0, 0,   1, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 3, 1, 1);
        add(C_NOP,  2'b00, 0, 0, 0, 0,   1, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 1);
        // lw r7; beq r7,r0 taken -> stall holds redirect, then redirect
        add(C_LW,   2'b00, 0, 7, 0, 0,   1, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 1);
        add(C_BEQX, 2'b01, 7, 0, 0, 1,   0, 0, 2'b00, 1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 1);
        add(C_BEQX, 2'b01, 7, 0, 0, 1,   1, 1, 2'b01, 0, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 0, 0, 1);
        add(C_NOP,  2'b00, 0, 0, 0, 0,   1, 0, 2'b00, 0, 2'b01, 2'b01, 2'b00, 0, 0, 1, 1, 7, 1, 1);
        // lw r0; add using r0 -> no stall, no forward
        add(C_LW,   2'b00, 0, 0, 0, 0,   1, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 0);
        add(C_R,    2'b10, 0, 0, 8, 0,   1, 0, 2'b00, 1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 1);
        add(C_NOP,  2'b00, 0, 0, 0, 0,   1, 0, 2'b00, 0, 2'b10, 2'b00, 2'b00, 1, 0, 0, 0, 0, 1, 1);
        add(C_NOP,  2'b00, 0, 0, 0, 0,   1, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 0, 1, 1, 0, 1, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].ctl, vecs[i].aop, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].eq);
            @(negedge clk_i);
            cmp_all($sformatf("vec%0d", i), vecs[i]);
            @(posedge clk_i); #1;
        end

        // ---- asynchronous reset in the middle of a stall ----
        rst_i = 1'b1; #1; rst_i = 1'b0;
        drive(C_LW, 2'b00, 5'd0, 5'd9, 5'd0, 1'b0);
        @(posedge clk_i); #1;
        drive(C_BEQ, 2'b01, 5'd9, 5'd0, 5'd0, 1'b1);
        @(negedge clk_i);
        chk("midstall PCWrite", int'(PCWrite_o), 0);
        chk("midstall IFFlush", int'(IFFlush_o), 0);
        #1 rst_i = 1'b1;
        #1;
        chk("rstasync PCWrite",   int'(PCWrite_o),   1);
        chk("rstasync IFIDWrite", int'(IFIDWrite_o), 1);
        chk("rstasync IFFlush",   int'(IFFlush_o),   1);
        chk("rstasync PCSrc",     int'(PCSrc_o),     1);
        chk("rstasync ALUSrc_ex", int'(ALUSrc_ex_o), 0);
        drive(C_ADDI, 2'b01, 5'd0, 5'd3, 5'd0, 1'b0);
        #1 rst_i = 1'b0;
        @(posedge clk_i); #1;
        drive(C_NOP, 2'b00, 5'd0, 5'd0, 5'd0, 1'b0);
        #1;
        chk("postrst ALUSrc_ex", int'(ALUSrc_ex_o), 1);
        chk("postrst ALUOp_ex",  int'(ALUOp_ex_o),  1);
        chk("postrst PCWrite",   int'(PCWrite_o),   1);

        // ---- randomized stimulus against the model ----
        rst_i = 1'b1; #1; rst_i = 1'b0;
        model_reset();
        for (int n = 0; n < 3000; n++) begin
            drive(8'($urandom), 2'($urandom), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom));
            // bias toward plausible instructions so hazards occur often
            if ($urandom_range(0, 3) != 0) begin
                Jump_i = 1'b0;
                Branch_i = ($urandom_range(0, 5) == 0);
                MemWrite_i = ($urandom_range(0, 5) == 0);
            end
            e = model_expect();
            @(negedge clk_i);
            cmp_all($sformatf("rnd%0d", n), e);
            @(posedge clk_i);
            model_clock();
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
